// File: rtl/histo_pkg.sv
// histo_pkg: shared widths, build FSM states and the fixed-point LUT reciprocal.
package histo_pkg;
    localparam int BIN_CNT = 256;
    localparam int ADDR_W  = 8;
    localparam int LUT_W   = 8;
    localparam int GREY_W  = 12;
    localparam int CUM_W   = 20;
    localparam int RECIP_W = 14;
    localparam int FRAC    = 24;
    localparam int PROD_W  = CUM_W + RECIP_W;
    localparam longint unsigned TOTAL_PIX = 64'd307200;
    // round(255 * 2^FRAC / TOTAL_PIX) evaluates to 13926
    localparam longint unsigned RECIP_FULL = ((64'd255 << FRAC) + TOTAL_PIX / 64'd2) / TOTAL_PIX;
    localparam logic [RECIP_W-1:0] RECIP = RECIP_W'(RECIP_FULL);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
endpackage

// File: rtl/histo_eq_mapper_lut_bank.sv
// lut_bank: 256x8 simple dual-port LUT RAM, one write port and one registered read port.
module lut_bank
    import histo_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [LUT_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [LUT_W-1:0]  rdata_o
);
    logic [LUT_W-1:0] mem_q [BIN_CNT];
    logic [LUT_W-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/histo_eq_mapper.sv
// histo_eq_mapper: builds a ping-pong equalisation LUT from the cumulative histogram and remaps grey pixels.
// Optional binarised output enabled by defining HISTO_EQ_BIN_EN.
module histo_eq_mapper
    import histo_pkg::*;
(
    input  logic              iPclk,
    input  logic              iRST,
    input  logic              iFval,
    input  logic              iDval,
    input  logic [GREY_W-1:0] iGrey,
    input  logic              iStart,
    output logic [ADDR_W-1:0] oCum_Addr,
    input  logic [CUM_W-1:0]  iCum_Q,
    input  logic [LUT_W-1:0]  iThresh,
    output logic [GREY_W-1:0] oGrey_Eq,
    output logic              oDval,
    output logic              oBin,
    output logic              oBusy,
    output logic              oLut_Ready
);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        case (state_q)
            IDLE:  begin
                cnt_d   = '0;
                state_d = iStart ? READ : IDLE;
            end
            READ:  state_d = (&cnt_q) ? DRAIN : READ;
            DRAIN: state_d = cnt_q[0] ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    assign oBusy     = state_q != IDLE;
    assign oCum_Addr = (state_q == READ) ? cnt_q : '0;

    logic v1_q, v2_q;
    logic [ADDR_W-1:0] a1_q, a2_q;
    logic [CUM_W-1:0] cum_q;
    logic fval_q, act_q, pend_q, ready_q;
    logic swap;
    assign swap = iFval & ~fval_q & pend_q & (state_q == IDLE);
    always_ff @(posedge iPclk or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            a1_q    <= '0;
            a2_q    <= '0;
            cum_q   <= '0;
            fval_q  <= 1'b0;
            act_q   <= 1'b0;
            pend_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_q    <= state_q == READ;
            v2_q    <= v1_q;
            a1_q    <= cnt_q;
            a2_q    <= a1_q;
            cum_q   <= iCum_Q;
            fval_q  <= iFval;
            act_q   <= act_q ^ swap;
            pend_q  <= (state_q == DONE) | (pend_q & ~swap);
            ready_q <= ready_q | swap;
        end
    end
    assign oLut_Ready = ready_q;

    // Keep only the integer part; anything above 255 saturates.
    logic [PROD_W-FRAC-1:0] prod_hi;
    logic [LUT_W-1:0] lut_w;
    assign prod_hi = (PROD_W-FRAC)'((PROD_W'(cum_q) * PROD_W'(RECIP)) >> FRAC);
    assign lut_w   = |prod_hi[PROD_W-FRAC-1:LUT_W] ? '1 : prod_hi[LUT_W-1:0];

    logic [LUT_W-1:0] rd0, rd1, lut_rd;
    lut_bank u_bank0 (.clk_i(iPclk), .we_i(v2_q & act_q), .waddr_i(a2_q), .wdata_i(lut_w),
                      .raddr_i(iGrey[GREY_W-1:GREY_W-ADDR_W]), .rdata_o(rd0));
    lut_bank u_bank1 (.clk_i(iPclk), .we_i(v2_q & ~act_q), .waddr_i(a2_q), .wdata_i(lut_w),
                      .raddr_i(iGrey[GREY_W-1:GREY_W-ADDR_W]), .rdata_o(rd1));

    logic [GREY_W-1:0] g1_q, ge_q;
    logic dv1_q, sel1_q, rdy1_q, dv_q;
    assign lut_rd = sel1_q ? rd1 : rd0;
    always_ff @(posedge iPclk or posedge iRST) begin
        if (iRST) begin
            g1_q   <= '0;
            dv1_q  <= 1'b0;
            sel1_q <= 1'b0;
            rdy1_q <= 1'b0;
            ge_q   <= '0;
            dv_q   <= 1'b0;
        end else begin
            g1_q   <= iGrey;
            dv1_q  <= iDval;
            sel1_q <= act_q;
            rdy1_q <= ready_q;
            ge_q   <= rdy1_q ? {lut_rd, lut_rd[LUT_W-1:LUT_W-4]} : g1_q;
            dv_q   <= dv1_q;
        end
    end
    assign oGrey_Eq = ge_q;
    assign oDval    = dv_q;

`ifdef HISTO_EQ_BIN_EN
    logic bin_q;
    always_ff @(posedge iPclk or posedge iRST) begin
        if (iRST) bin_q <= 1'b0;
        else      bin_q <= rdy1_q & (lut_rd >= iThresh);
    end
    assign oBin = bin_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^iThresh;
    assign oBin = 1'b0;
`endif
endmodule
